// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode-side handshake.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        out_fault;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, out_fault,
        input  imem_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, out_fault,
        output imem_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures imem data into a 2-entry buffer, feeds decode.
// Optional out-of-range fault tagging enabled by FETCH_BOUNDS_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef FETCH_BOUNDS_CHECK_EN
        logic        fault;
`endif
    } entry_t;

    logic [31:0] pc;
    entry_t      buf_q [2];
    entry_t      out_q;
    logic        head, tail, out_valid_q;
    logic [1:0]  count, count_nxt;
    logic        pop, push, nxt_idx;
    entry_t      cap, head_nxt;

    assign pop       = out_valid_q & bus.out_ready & ~bus.redirect_valid;
    assign push      = ~bus.redirect_valid & ((count < 2'd2) | pop);
    assign count_nxt = count - {1'b0, pop} + {1'b0, push};
    assign nxt_idx   = pop ? ~head : head;

    always_comb begin
        cap       = '0;
        cap.pc    = pc;
        cap.instr = bus.imem_data;
`ifdef FETCH_BOUNDS_CHECK_EN
        if ({2'b00, pc[31:2]} >= 32'(IMEM_DEPTH)) begin
            cap.instr = NOP;
            cap.fault = 1'b1;
        end
`endif
    end

    // Content of the head slot as it will look after this edge's write.
    always_comb begin
        head_nxt = buf_q[nxt_idx];
        if (push && (tail == nxt_idx))
            head_nxt = cap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC & ~32'h3;
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else if (bus.redirect_valid) begin
            pc          <= bus.redirect_pc & ~32'h3;
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                buf_q[tail] <= cap;
                tail        <= ~tail;
                pc          <= pc + 32'd4;
            end
            if (pop)
                head <= ~head;
            count       <= count_nxt;
            out_valid_q <= (count_nxt != 2'd0);
            // Outputs only move to a valid entry; otherwise they keep the last one shown.
            if (count_nxt != 2'd0)
                out_q <= head_nxt;
        end
    end

    assign bus.imem_addr    = {2'b00, pc[31:2]};
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_q.pc;
    assign bus.out_instr    = out_q.instr;
    assign bus.out_pc_plus4 = out_q.pc + 32'd4;
`ifdef FETCH_BOUNDS_CHECK_EN
    assign bus.out_fault    = out_q.fault;
`else
    assign bus.out_fault    = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic vs a queue model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h4;
    localparam int          DEPTH    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .IMEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        if (w == 32'd1) return 32'h0010_2283;
        if (w == 32'd2) return 32'h0020_2303;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    // Reference model: queue of fetched byte PCs plus the next PC to fetch.
    logic [31:0] q_pc [$];
    logic [31:0] m_pc, last_pc, last_instr;
    logic        last_fault;

    function automatic logic exp_fault(input logic [31:0] p);
`ifdef FETCH_BOUNDS_CHECK_EN
        return (p / 4) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] p);
        return exp_fault(p) ? 32'h0000_0013 : mem_word(p / 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(bus.out_valid), 32'(q_pc.size() > 0));
        chk("imem_addr", bus.imem_addr, m_pc / 4);
        chk("out_pc", bus.out_pc, last_pc);
        chk("out_instr", bus.out_instr, last_instr);
        chk("out_pc_plus4", bus.out_pc_plus4, last_pc + 32'd4);
        chk("out_fault", 32'(bus.out_fault), 32'(last_fault));
    endtask

    task automatic model_reset();
        q_pc.delete();
        m_pc       = RESET_PC & ~32'h3;
        last_pc    = '0;
        last_instr = '0;
        last_fault = 1'b0;
    endtask

    // Drive one cycle of inputs, update the model at the edge, check at the next negedge.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(posedge clk);
        if (rv) begin
            q_pc.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            if (q_pc.size() > 0 && rdy) void'(q_pc.pop_front());
            if (q_pc.size() < 2) begin
                q_pc.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        if (q_pc.size() > 0) begin
            last_pc    = q_pc[0];
            last_instr = exp_instr(q_pc[0]);
            last_fault = exp_fault(q_pc[0]);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        model_reset();

        // Reset state and first fetches.
        apply_reset();
        chk("rst_addr", bus.imem_addr, 32'd1);
        chk("rst_plus4", bus.out_pc_plus4, 32'd4);
        cycle(1'b0, '0, 1'b1);
        chk("first_pc", bus.out_pc, 32'd4);
        chk("first_instr", bus.out_instr, 32'h0010_2283);
        chk("first_plus4", bus.out_pc_plus4, 32'd8);
        cycle(1'b0, '0, 1'b1);
        chk("second_pc", bus.out_pc, 32'd8);
        chk("second_instr", bus.out_instr, 32'h0020_2303);

        // Back-pressure from reset: buffer fills, PC freezes at RESET_PC+8.
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);
        held = bus.imem_addr;
        chk("stall_addr", held, (RESET_PC + 32'd8) / 4);
        cycle(1'b0, '0, 1'b0);
        chk("stall_addr_hold", bus.imem_addr, held);
        chk("stall_head", bus.out_pc, 32'd4);
        cycle(1'b0, '0, 1'b1);
        chk("drain0", bus.out_pc, 32'd8);
        cycle(1'b0, '0, 1'b1);
        chk("drain1", bus.out_pc, 32'd12);

        // Redirect while full.
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h0000_0027, 1'b0);
        chk("redir_bubble", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("redir_pc", bus.out_pc, 32'h24);
        chk("redir_instr", bus.out_instr, mem_word(32'd9));

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_addr", bus.imem_addr, RESET_PC / 4);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b1);
        chk("post_async_pc", bus.out_pc, RESET_PC);

        // PC wrap.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus.out_pc_plus4, 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("wrap_next", bus.out_pc, 32'd0);

`ifdef FETCH_BOUNDS_CHECK_EN
        cycle(1'b1, 32'h80, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("oob_instr", bus.out_instr, 32'h0000_0013);
        chk("oob_fault", 32'(bus.out_fault), 32'd1);
        cycle(1'b1, 32'h7C, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("inb_fault", 32'(bus.out_fault), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 160));
            cycle(rv, rpc, 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the program counter and drives the instruction memory's word-index address.
- Captures the combinational read data into a 2-entry fetch buffer and presents {pc, instr} to decode over a valid/ready handshake.
- Supports stall (back-pressure) and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_DEPTH, 32, number of 32-bit words in the instruction memory; used only by the optional bounds check.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  word index to instruction memory = {2'b00, pc[31:2]}, combinational from the PC register.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  taken branch/jump from execute; flush and reload the PC.
- redirect_pc  input  32  redirect target byte address; bits [1:0] ignored (forced to 0).
- out_valid  output  1  head buffer entry valid.
- out_ready  input  1  decode accepts the head entry this cycle.
- out_instr  output  32  head entry instruction.
- out_pc  output  32  head entry byte PC.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- out_fault  output  1  head entry fetched out of range (optional feature only; otherwise tied 0).

Behaviour:
- State:
  - pc[31:0], with pc[1:0] always 0.
  - Buffer of 2 entries {pc, instr, fault}, organised as head/tail pointers plus count[1:0] in the range 0..2.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - pc = RESET_PC & ~3, count = 0, pointers = 0.
  - out_valid = 0; out_instr, out_pc and out_fault read 0; out_pc_plus4 = 4.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & (count < 2 | pop).
- On push at a rising edge:
  - {pc, imem_data} is written at the tail.
  - pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 0.
- Stall: when count = 2 and pop = 0, push = 0.
  - pc holds and imem_addr is stable.
  - The buffer contents are unchanged.
- Simultaneous pop and push at count = 2 is allowed; count stays 2.
- Redirect, at a rising edge with redirect_valid = 1:
  - count <= 0 and pointers reset, flushing both entries regardless of out_ready.
  - pc <= redirect_pc & ~3.
  - No push occurs that cycle.
- Redirect penalty is exactly 1 bubble cycle: the target instruction is captured on the next edge, and out_valid rises after that edge.
- Latency: after rst deasserts, the first edge captures the instruction at RESET_PC; out_valid = 1 after that edge.
- Throughput: 1 instruction per cycle while out_ready = 1.
- out_* are registered and come from the head entry; they do not change while out_valid = 1 and out_ready = 0.
- When out_valid = 0, out_* hold their last values; decode must ignore them.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - If pc[31:2] >= IMEM_DEPTH at push, the entry's instr is forced to NOP 32'h0000_0013 and fault = 1.
  - out_fault reflects the head entry's fault bit.
- Undefined:
  - imem_data is captured unchanged.
  - out_fault is tied 0 and the fault storage is omitted.

Test Plan:
- Reset with RESET_PC = 4, out_ready = 1, memory loaded with 32'h00102283 at word 1 and 32'h00202303 at word 2.
  - imem_addr = 1 during reset.
  - Output 1: out_pc = 4, out_instr = 32'h00102283, out_pc_plus4 = 8.
  - Next cycle: out_pc = 8, out_instr = 32'h00202303.
- Back-pressure: out_ready = 0 for 5 cycles from reset.
  - count reaches 2; pc freezes at RESET_PC + 8 and imem_addr stays constant.
  - Raising out_ready drains PCs 4, 8, 12 in order with no loss or duplication.
- Redirect with redirect_pc = 32'h0000_0027 while count = 2.
  - Next cycle: out_valid = 0.
  - Following cycle: out_pc = 32'h24, out_instr = word 9.
- Asynchronous reset asserted mid-cycle while out_valid = 1.
  - out_valid drops immediately without waiting for clk.
  - pc returns to RESET_PC.
- Wrap: redirect to 32'hFFFF_FFFC.
  - The next fetched out_pc is 0, and out_pc_plus4 of the first entry is 0.
- With FETCH_BOUNDS_CHECK_EN: redirect to 32'h80 (word 32).
  - out_instr = 32'h00000013, out_fault = 1.
  - Redirect to 32'h7C: out_fault = 0.
